// File: rtl/lane_shift_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lane_shift_pkg
// Brief    : Mode encodings and elaboration helpers for the lane rotator/shifter.
// Revision : 1.0
// ============================================================================
package lane_shift_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_ROL = 3'd0;
    localparam logic [MODE_W-1:0] MODE_ROR = 3'd1;
    localparam logic [MODE_W-1:0] MODE_SLL = 3'd2;
    localparam logic [MODE_W-1:0] MODE_SRL = 3'd3;
    localparam logic [MODE_W-1:0] MODE_SRA = 3'd4;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lane_shift_level.sv
`default_nettype none
// ============================================================================
// Module   : lane_shift_level
// Brief    : One combinational log-shifter level moving by 2^LEVEL lanes.
// Revision : 1.0
// ============================================================================
module lane_shift_level
    import lane_shift_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int GRAN_W = 8,
    parameter int LEVEL  = 0
) (
    input  logic [DATA_W-1:0] data_i,
    input  logic              en_i,
    input  logic [MODE_W-1:0] mode_i,
    input  logic              sign_i,
    output logic [DATA_W-1:0] data_o
);

    localparam int SH = GRAN_W * (2 ** LEVEL);
    localparam logic [DATA_W-1:0] FILL_MASK = ~({DATA_W{1'b1}} >> SH);

    // Reserved modes fall through to the default and leave the data untouched.
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (mode_i)
                MODE_ROL: data_o = (data_i << SH) | (data_i >> (DATA_W - SH));
                MODE_ROR: data_o = (data_i >> SH) | (data_i << (DATA_W - SH));
                MODE_SLL: data_o = data_i << SH;
                MODE_SRL: data_o = data_i >> SH;
                MODE_SRA: data_o = (data_i >> SH) | (sign_i ? FILL_MASK : '0);
                default:  data_o = data_i;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/lane_rotate_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lane_rotate_shift_pipe
// Brief    : Pipelined lane-granular rotate/shift with valid/ready handshake.
// Revision : 1.0
// ============================================================================
module lane_rotate_shift_pipe
    import lane_shift_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int GRAN_W = 8,
    parameter  int STAGES = 1,
    localparam int AMT_W  = clog2(DATA_W / GRAN_W)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] operand_i,
    input  logic [AMT_W-1:0]  amount_i,
    input  logic [MODE_W-1:0] mode_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              err_o
);

    localparam int LANES    = DATA_W / GRAN_W;
    localparam int LEVELS   = AMT_W;
    localparam int SAFE_STG = (STAGES < 1) ? 1 : STAGES;
    localparam int GRP      = (LEVELS + SAFE_STG - 1) / SAFE_STG;

    if ((DATA_W % GRAN_W) != 0) begin : g_chk_div
        $fatal(1, "DATA_W must be a multiple of GRAN_W");
    end
    if ((LANES & (LANES - 1)) != 0) begin : g_chk_pow2
        $fatal(1, "DATA_W/GRAN_W must be a power of two");
    end
    if ((STAGES < 1) || (STAGES > LEVELS)) begin : g_chk_stages
        $fatal(1, "STAGES must lie in 1..LEVELS");
    end

    logic [DATA_W-1:0] w_in_data  [STAGES];
    logic [DATA_W-1:0] w_out_data [STAGES];
    logic [AMT_W-1:0]  w_in_amt   [STAGES];
    logic [MODE_W-1:0] w_in_mode  [STAGES];
    logic              w_in_sign  [STAGES];
    logic              w_in_err   [STAGES];
    logic              w_in_vld   [STAGES];

    logic [DATA_W-1:0] data_q [STAGES];
    logic [AMT_W-1:0]  amt_q  [STAGES];
    logic [MODE_W-1:0] mode_q [STAGES];
    logic              sign_q [STAGES];
    logic              err_q  [STAGES];
    logic              vld_q  [STAGES];

    logic [STAGES-1:0] w_load;
    logic              w_unused;

    // A stage loads when empty or when its current beat moves downstream.
    always_comb begin
        w_load = '0;
        w_load[STAGES-1] = !vld_q[STAGES-1] || ready_i;
        for (int k = STAGES - 2; k >= 0; k--) begin
            w_load[k] = !vld_q[k] || w_load[k+1];
        end
    end

    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^{w_in_amt[k], amt_q[k], mode_q[k], sign_q[k]});
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stg
        localparam int FIRST = k * GRP;
        localparam int LAST  = (((k + 1) * GRP < LEVELS) ? (k + 1) * GRP : LEVELS) - 1;

        if (k == 0) begin : g_head
            assign w_in_data[k] = operand_i;
            assign w_in_amt[k]  = amount_i;
            assign w_in_mode[k] = mode_i;
            assign w_in_sign[k] = operand_i[DATA_W-1];
            assign w_in_err[k]  = (mode_i > MODE_SRA);
            assign w_in_vld[k]  = valid_i;
        end else begin : g_body
            assign w_in_data[k] = data_q[k-1];
            assign w_in_amt[k]  = amt_q[k-1];
            assign w_in_mode[k] = mode_q[k-1];
            assign w_in_sign[k] = sign_q[k-1];
            assign w_in_err[k]  = err_q[k-1];
            assign w_in_vld[k]  = vld_q[k-1];
        end

        if (FIRST < LEVELS) begin : g_levels
            assign w_out_data[k] = g_lvl[LAST].w_out;
        end else begin : g_pass
            assign w_out_data[k] = w_in_data[k];
        end

        // Payload only updates on a valid beat so the last result holds once the pipe drains.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q[k]  <= 1'b0;
                data_q[k] <= '0;
                amt_q[k]  <= '0;
                mode_q[k] <= '0;
                sign_q[k] <= 1'b0;
                err_q[k]  <= 1'b0;
            end else if (w_load[k]) begin
                vld_q[k] <= w_in_vld[k];
                if (w_in_vld[k]) begin
                    data_q[k] <= w_out_data[k];
                    amt_q[k]  <= w_in_amt[k];
                    mode_q[k] <= w_in_mode[k];
                    sign_q[k] <= w_in_sign[k];
                    err_q[k]  <= w_in_err[k];
                end
            end
        end
    end

    for (genvar j = 0; j < LEVELS; j++) begin : g_lvl
        localparam int S = j / GRP;
        logic [DATA_W-1:0] w_in;
        logic [DATA_W-1:0] w_out;

        if ((j % GRP) == 0) begin : g_first
            assign w_in = w_in_data[S];
        end else begin : g_next
            assign w_in = g_lvl[j-1].w_out;
        end

        lane_shift_level #(
            .DATA_W (DATA_W),
            .GRAN_W (GRAN_W),
            .LEVEL  (j)
        ) u_level (
            .data_i (w_in),
            .en_i   (w_in_amt[S][j]),
            .mode_i (w_in_mode[S]),
            .sign_i (w_in_sign[S]),
            .data_o (w_out)
        );
    end

    assign ready_o  = w_load[0];
    assign valid_o  = vld_q[STAGES-1];
    assign result_o = data_q[STAGES-1];
    assign err_o    = err_q[STAGES-1];

endmodule
`default_nettype wire
